accum_cpu: RTL and testbench

//  Parametrised multi-cycle accumulator CPU (A/B registers, PC) on a single shared memory port.

---
 rtl/accum_cpu_pkg.sv | 36 +++
 rtl/accum_cpu_alu.sv | 33 +++
 rtl/accum_cpu.sv | 152 +++++++++++++++
 tb/tb_accum_cpu.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_cpu_pkg.sv
// rtl/accum_cpu_pkg.sv - opcodes, FSM state type and width limit shared by accum_cpu
package accum_cpu_pkg;

    localparam int MIN_DATA_W = 8;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LDA = 8'h01;
    localparam logic [7:0] OP_STA = 8'h02;
    localparam logic [7:0] OP_MPA = 8'h03;
    localparam logic [7:0] OP_MAP = 8'h04;
    localparam logic [7:0] OP_MBA = 8'h05;
    localparam logic [7:0] OP_MAB = 8'h06;
    localparam logic [7:0] OP_LDI = 8'h07;
    localparam logic [7:0] OP_JMP = 8'h08;
    localparam logic [7:0] OP_JZ  = 8'h09;
    localparam logic [7:0] OP_HLT = 8'h0F;
    localparam logic [7:0] OP_ADD = 8'h10;
    localparam logic [7:0] OP_SUB = 8'h11;
    localparam logic [7:0] OP_MUL = 8'h12;
    localparam logic [7:0] OP_DIV = 8'h13;
    localparam logic [7:0] OP_AND = 8'h14;
    localparam logic [7:0] OP_OR  = 8'h15;
    localparam logic [7:0] OP_XOR = 8'h16;
    localparam logic [7:0] OP_NOT = 8'h17;

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_OPND,
        S_MEM,
        S_WRITE,
        S_HALT
    } state_t;

endpackage

// File: rtl/accum_cpu_alu.sv
// rtl/accum_cpu_alu.sv - combinational a-op-b unit; MUL/DIV present only with ACCUM_CPU_MULDIV_EN
module accum_cpu_alu
    import accum_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [7:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = a;
        case (op)
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
`ifdef ACCUM_CPU_MULDIV_EN
            OP_MUL: y = a * b;
            // Division by zero saturates instead of producing an undefined quotient.
            OP_DIV: y = (b == '0) ? '1 : a / b;
`else
            OP_MUL, OP_DIV: y = a;
`endif
            default: y = a;
        endcase
    end

endmodule

// File: rtl/accum_cpu.sv
// rtl/accum_cpu.sv - multi-cycle accumulator CPU on one shared memory port (MUL/DIV via ACCUM_CPU_MULDIV_EN)
module accum_cpu
    import accum_cpu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out,
    output logic              we,
    output logic              halted
);

    if (DATA_W < MIN_DATA_W) begin : g_width_check
        $error("accum_cpu: DATA_W must be at least 8");
    end

    localparam logic [1:0]        LAT_M1 = (MEM_LAT > 0) ? 2'(MEM_LAT - 1) : 2'd0;
    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PC_TWO = ADDR_W'(2);

    state_t            state, state_n, ret, ret_n;
    logic [1:0]        cnt, cnt_n;
    logic [ADDR_W-1:0] pc, pc_n, addr_n, opnd_addr;
    logic [DATA_W-1:0] a, a_n, b, b_n, dout_n, alu_y;
    logic [7:0]        inst, inst_n, op_now;
    logic              we_n;

    assign op_now    = data_in[7:0];
    assign opnd_addr = ADDR_W'(data_in);
    assign halted    = (state == S_HALT);

    accum_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op (op_now),
        .a  (a),
        .b  (b),
        .y  (alu_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            ret      <= S_FETCH;
            cnt      <= '0;
            pc       <= '0;
            a        <= '0;
            b        <= '0;
            inst     <= '0;
            addr     <= '0;
            data_out <= '0;
            we       <= 1'b0;
        end else begin
            state    <= state_n;
            ret      <= ret_n;
            cnt      <= cnt_n;
            pc       <= pc_n;
            a        <= a_n;
            b        <= b_n;
            inst     <= inst_n;
            addr     <= addr_n;
            data_out <= dout_n;
            we       <= we_n;
        end
    end

    // Every read goes through WAIT for MEM_LAT cycles (skipped when MEM_LAT is 0);
    // ret remembers which state samples data_in afterwards.
    always_comb begin
        state_n = state;
        ret_n   = ret;
        cnt_n   = cnt;
        pc_n    = pc;
        a_n     = a;
        b_n     = b;
        inst_n  = inst;
        addr_n  = addr;
        dout_n  = data_out;
        we_n    = 1'b0;
        case (state)
            S_FETCH: begin
                addr_n  = pc;
                state_n = (MEM_LAT == 0) ? S_DECODE : S_WAIT;
                ret_n   = S_DECODE;
                cnt_n   = LAT_M1;
            end
            S_WAIT: begin
                if (cnt == 2'd0) state_n = ret;
                else             cnt_n   = cnt - 2'd1;
            end
            S_DECODE: begin
                inst_n  = op_now;
                state_n = S_FETCH;
                pc_n    = pc + PC_ONE;
                case (op_now)
                    OP_NOP: ;
                    OP_LDA, OP_STA, OP_LDI, OP_JMP, OP_JZ: begin
                        addr_n  = pc + PC_ONE;
                        pc_n    = pc;
                        state_n = (MEM_LAT == 0) ? S_OPND : S_WAIT;
                        ret_n   = S_OPND;
                        cnt_n   = LAT_M1;
                    end
                    OP_MPA: a_n = DATA_W'(pc);
                    OP_MAP: pc_n = ADDR_W'(a);
                    OP_MBA: a_n = b;
                    OP_MAB: b_n = a;
                    OP_HLT: begin
                        pc_n    = pc;
                        state_n = S_HALT;
                    end
                    default: if (op_now[7:3] == 5'b00010) a_n = alu_y;
                endcase
            end
            S_OPND: begin
                state_n = S_FETCH;
                pc_n    = pc + PC_TWO;
                case (inst)
                    OP_LDI: a_n = data_in;
                    OP_JMP: pc_n = opnd_addr;
                    OP_JZ:  if (a == '0) pc_n = opnd_addr;
                    OP_LDA: begin
                        addr_n  = opnd_addr;
                        pc_n    = pc;
                        state_n = (MEM_LAT == 0) ? S_MEM : S_WAIT;
                        ret_n   = S_MEM;
                        cnt_n   = LAT_M1;
                    end
                    OP_STA: begin
                        addr_n  = opnd_addr;
                        dout_n  = a;
                        we_n    = 1'b1;
                        state_n = S_WRITE;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                a_n     = data_in;
                pc_n    = pc + PC_TWO;
                state_n = S_FETCH;
            end
            S_WRITE: state_n = S_FETCH;
            S_HALT:  state_n = S_HALT;
            default: state_n = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_accum_cpu.sv
// tb/tb_accum_cpu.sv - self-checking bench for accum_cpu (vector table, corner sequences, random programs)
module tb_accum_cpu;

    parameter int MEM_LAT = 1;
    localparam int L = MEM_LAT;
`ifdef ACCUM_CPU_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif
    localparam logic [159:0] OPS = 160'h00010203_04050607_08090F10_11121314_1516170A;

    typedef struct packed {
        logic [95:0] code;
        logic [7:0]  xaddr;
        logic [31:0] xdat;
        logic [7:0]  ea, eb, epc, ewa, ewd, nw, c0, cl;
    } vec_t;

    logic       clk, rst, we, halted, load_img;
    logic [7:0] data_in, addr, data_out, rd_addr;
    logic [23:0] ahist;
    logic [7:0] mem [256];
    logic [7:0] img [256];
    logic [7:0] ref_mem [256];
    int checks = 0, errors = 0, nwrites = 0;
    vec_t vt [12];

    accum_cpu #(.DATA_W(8), .ADDR_W(8), .MEM_LAT(MEM_LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .addr     (addr),
        .data_out (data_out),
        .we       (we),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_img) mem <= img;
        else if (we) mem[addr] <= data_out;
        if (we) nwrites <= nwrites + 1;
        ahist <= {ahist[15:0], addr};
    end

    always_comb begin
        case (MEM_LAT)
            0:       rd_addr = addr;
            1:       rd_addr = ahist[7:0];
            2:       rd_addr = ahist[15:8];
            default: rd_addr = ahist[23:16];
        endcase
    end
    assign data_in = mem[rd_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        load_img = 1'b1;
        @(posedge clk); #1;
        load_img = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_halt(input int maxc, output int cyc);
        cyc = 0;
        while (halted !== 1'b1 && cyc < maxc) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    // Instruction-level interpreter over ref_mem, with the documented cycle cost of each instruction.
    task automatic model_run(input int maxi, output logic [7:0] ra, output logic [7:0] rb,
                             output logic [7:0] rpc, output bit rh, output int cyc);
        logic [7:0] a, b, pc, op, o, pn;
        a = 0; b = 0; pc = 0; rh = 0; cyc = 0;
        for (int n = 0; n < maxi && !rh; n++) begin
            op = ref_mem[pc];
            o  = ref_mem[8'(pc + 8'd1)];
            case (op)
                8'h01: begin a = ref_mem[o]; pc = pc + 8'd2; cyc += 4 + 3 * L; end
                8'h02: begin ref_mem[o] = a; pc = pc + 8'd2; cyc += 4 + 2 * L; end
                8'h07: begin a = o; pc = pc + 8'd2; cyc += 3 + 2 * L; end
                8'h08: begin pc = o; cyc += 3 + 2 * L; end
                8'h09: begin pc = (a == 0) ? o : pc + 8'd2; cyc += 3 + 2 * L; end
                8'h0F: begin rh = 1; cyc += 2 + L; end
                default: begin
                    cyc += 2 + L;
                    pn = pc + 8'd1;
                    case (op)
                        8'h03: a = pc;
                        8'h04: pn = a;
                        8'h05: a = b;
                        8'h06: b = a;
                        8'h10: a = a + b;
                        8'h11: a = a - b;
                        8'h12: if (MULDIV) a = a * b;
                        8'h13: if (MULDIV) a = (b == 0) ? 8'hFF : a / b;
                        8'h14: a = a & b;
                        8'h15: a = a | b;
                        8'h16: a = a ^ b;
                        8'h17: a = ~a;
                        default: ;
                    endcase
                    pc = pn;
                end
            endcase
        end
        ra = a; rb = b; rpc = pc;
    endtask

    initial begin
        int cyc, n, w0, k, bad;
        logic [7:0] idx, ma, mb, mpc;
        bit mh;

        rst = 1'b1;
        load_img = 1'b0;

        vt[0]  = '{96'h07050607_03100280_0F000000, 8'hF0, 32'h0, 8'h08, 8'h05, 8'h08, 8'h80, 8'h08, 8'd1, 8'd16, 8'd9};
        vt[1]  = '{96'h01400F00_00000000_00000000, 8'h40, 32'hA5000000, 8'hA5, 8'h00, 8'h02, 8'h40, 8'hA5, 8'd0, 8'd6, 8'd4};
        vt[2]  = '{96'h07030607_0A110F00_00000000, 8'hF0, 32'h0, 8'h07, 8'h03, 8'h06, 8'h80, 8'h00, 8'd0, 8'd12, 8'd7};
        vt[3]  = '{96'h070F0607_3C141516_170F0000, 8'hF0, 32'h0, 8'hFF, 8'h0F, 8'h09, 8'h80, 8'h00, 8'd0, 8'd18, 8'd10};
        vt[4]  = '{96'h07010607_00110F00_00000000, 8'hF0, 32'h0, 8'hFF, 8'h01, 8'h06, 8'h80, 8'h00, 8'd0, 8'd12, 8'd7};
        vt[5]  = '{96'h07090607_0A040F0F_0F0F0503, 8'h0C, 32'h0F000000, 8'h0B, 8'h09, 8'h0C, 8'h80, 8'h00, 8'd0, 8'd16, 8'd9};
        vt[6]  = '{96'h07000920_0F000000_00000000, 8'h20, 32'h0F000000, 8'h00, 8'h00, 8'h20, 8'h80, 8'h00, 8'd0, 8'd8, 8'd5};
        vt[7]  = '{96'h07010920_0F000000_00000000, 8'h20, 32'h0F000000, 8'h01, 8'h00, 8'h04, 8'h80, 8'h00, 8'd0, 8'd8, 8'd5};
        vt[8]  = '{96'h08100F00_00000000_00000000, 8'h10, 32'h07660F00, 8'h66, 8'h00, 8'h12, 8'h80, 8'h00, 8'd0, 8'd8, 8'd5};
        vt[9]  = '{96'h072A0A1F_FF0F0000_00000000, 8'hF0, 32'h0, 8'h2A, 8'h00, 8'h05, 8'h80, 8'h00, 8'd0, 8'd11, 8'd6};
        vt[10] = '{96'h07030607_07120F00_00000000, 8'hF0, 32'h0, MULDIV ? 8'h15 : 8'h07, 8'h03, 8'h06, 8'h80, 8'h00, 8'd0, 8'd12, 8'd7};
        vt[11] = '{96'h06070713_0F000000_00000000, 8'hF0, 32'h0, MULDIV ? 8'hFF : 8'h07, 8'h00, 8'h04, 8'h80, 8'h00, 8'd0, 8'd9, 8'd5};

        // Reset state
        clear_img();
        do_reset();
        chk("reset addr", addr, 0);
        chk("reset data_out", data_out, 0);
        chk("reset we", we, 0);
        chk("reset halted", halted, 0);
        chk("reset pc", dut.pc, 0);
        chk("reset a", dut.a, 0);
        chk("reset b", dut.b, 0);

        // Vector table
        for (int i = 0; i < 12; i++) begin
            clear_img();
            for (int j = 0; j < 12; j++) img[j] = vt[i].code[95 - 8 * j -: 8];
            for (int j = 0; j < 4; j++) begin
                idx = 8'(vt[i].xaddr + 8'(j));
                img[idx] = vt[i].xdat[31 - 8 * j -: 8];
            end
            do_reset();
            w0 = nwrites;
            wait_halt(400, cyc);
            chk($sformatf("vec%0d cycles", i), cyc, vt[i].c0 + vt[i].cl * L);
            chk($sformatf("vec%0d halted", i), halted, 1);
            chk($sformatf("vec%0d a", i), dut.a, vt[i].ea);
            chk($sformatf("vec%0d b", i), dut.b, vt[i].eb);
            chk($sformatf("vec%0d pc", i), dut.pc, vt[i].epc);
            chk($sformatf("vec%0d mem", i), mem[vt[i].ewa], vt[i].ewd);
            chk($sformatf("vec%0d writes", i), nwrites - w0, vt[i].nw);
        end

        // Reset while the store is on the bus, then reset while halted
        clear_img();
        img[0] = 8'h07; img[1] = 8'h55; img[2] = 8'h02; img[3] = 8'h80; img[4] = 8'h0F;
        do_reset();
        n = 0;
        while (we !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        chk("rstw we seen", we, 1);
        chk("rstw we cycle", n, 6 + 4 * L);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstw we", we, 0);
        chk("rstw pc", dut.pc, 0);
        chk("rstw addr", addr, 0);
        chk("rstw write done", mem[8'h80], 8'h55);
        rst = 1'b0;
        wait_halt(300, cyc);
        chk("rstw rerun cycles", cyc, 9 + 5 * L);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rsth halted", halted, 0);
        rst = 1'b0;
        wait_halt(300, cyc);
        chk("rsth refetch cycles", cyc, 9 + 5 * L);

        // PC wrap: NOP at FF falls through to 00
        clear_img();
        img[8'h00] = 8'h09; img[8'h01] = 8'h10; img[8'h02] = 8'h0F;
        img[8'h10] = 8'h07; img[8'h11] = 8'h01; img[8'h12] = 8'h08; img[8'h13] = 8'hFF;
        img[8'hFF] = 8'h00;
        do_reset();
        wait_halt(400, cyc);
        chk("wrapnop cycles", cyc, 16 + 10 * L);
        chk("wrapnop a", dut.a, 8'h01);
        chk("wrapnop pc", dut.pc, 8'h02);

        // Operand fetched from 00 after an opcode at FF
        clear_img();
        img[8'h00] = 8'h08; img[8'h01] = 8'hFF; img[8'h02] = 8'h0F; img[8'hFF] = 8'h07;
        do_reset();
        wait_halt(400, cyc);
        chk("wrapldi cycles", cyc, 10 + 6 * L);
        chk("wrapldi a", dut.a, 8'h08);
        chk("wrapldi pc", dut.pc, 8'h02);

        // Random programs against the interpreter
        for (int p = 0; p < 25; p++) begin
            for (int j = 0; j < 256; j++) begin
                k = $urandom_range(0, 9);
                if (k < 6) begin
                    n = $urandom_range(0, 19);
                    img[j] = OPS[159 - 8 * n -: 8];
                end else if (k < 8) img[j] = 8'($urandom);
                else if (k == 8)    img[j] = 8'h00;
                else                img[j] = 8'($urandom_range(0, 3));
            end
            ref_mem = img;
            model_run(40, ma, mb, mpc, mh, cyc);
            do_reset();
            run_cycles(cyc - 1);
            if (mh) chk($sformatf("rnd%0d early halt", p), halted, 0);
            run_cycles(1);
            chk($sformatf("rnd%0d halted", p), halted, mh);
            chk($sformatf("rnd%0d a", p), dut.a, ma);
            chk($sformatf("rnd%0d b", p), dut.b, mb);
            chk($sformatf("rnd%0d pc", p), dut.pc, mpc);
            bad = 0;
            for (int j = 0; j < 256; j++) if (mem[j] !== ref_mem[j]) bad++;
            chk($sformatf("rnd%0d mem bytes differing", p), bad, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
